// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of a 5-stage RISC-V pipeline.
// Holds the fetch PC, issues instruction-memory requests, and drives the
// IF/ID register (PC, Instruction) that feeds decode. Memory wait states
// become NOP bubbles. A one-entry skid buffer keeps an acknowledged word
// while decode stalls. Taken branches and jumps from EX flush the slot.
//
// Optional feature: define IF_STAGE_BUBBLE_CNT_EN to build a saturating
// counter of NOP bubbles loaded into IF/ID. Without it, bubble_cnt is 0.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        PCSel,
  input  logic [31:0] PC_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic [31:0] bubble_cnt
);

  // REQ: a fetch is outstanding at fetch_pc.
  // HOLD: an acknowledged word waits in the skid buffer for decode.
  localparam logic [0:0] REQ  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        load_nop;
  logic [31:0] fetch_pc_inc;

  // Redirect targets are word aligned. The two low bits are dropped.
  logic [1:0]  target_lsb_unused;
  assign target_lsb_unused = PC_target[1:0];

  // The increment wraps modulo 2^32, so 0xFFFF_FFFC is followed by 0.
  assign fetch_pc_inc = fetch_pc_reg + 32'd4;

  // Reset gates the request immediately, before the reset edge is seen.
  assign imem_req    = (state_reg == REQ) && reset_n;
  assign imem_addr   = fetch_pc_reg;
  assign PC          = pc_reg;
  assign Instruction = instr_reg;

  // Next-state logic. Priority is redirect, then stall, then normal flow.
  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    buf_pc_next    = buf_pc_reg;
    buf_instr_next = buf_instr_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    load_nop       = 1'b0;

    if (PCSel) begin
      // Flush: the slot being fetched is squashed and any buffered word is
      // dropped. An ack in this cycle belongs to the wrong path.
      fetch_pc_next  = {PC_target[31:2], 2'b00};
      pc_next        = fetch_pc_reg;
      instr_next     = NOP;
      load_nop       = 1'b1;
      buf_pc_next    = '0;
      buf_instr_next = '0;
      state_next     = REQ;
    end else if (state_reg == REQ) begin
      if (imem_ack && !stall) begin
        pc_next       = fetch_pc_reg;
        instr_next    = imem_rdata;
        fetch_pc_next = fetch_pc_inc;
      end else if (imem_ack && stall) begin
        // Decode cannot take the word yet, so it goes into the skid buffer.
        buf_pc_next    = fetch_pc_reg;
        buf_instr_next = imem_rdata;
        fetch_pc_next  = fetch_pc_inc;
        state_next     = HOLD;
      end else if (!stall) begin
        // Memory wait state: decode sees a bubble tagged with the pending PC.
        pc_next    = fetch_pc_reg;
        instr_next = NOP;
        load_nop   = 1'b1;
      end
    end else begin
      // HOLD: no request is issued, so any ack here is ignored.
      if (!stall) begin
        pc_next    = buf_pc_reg;
        instr_next = buf_instr_reg;
        state_next = REQ;
      end
    end
  end

  // State and IF/ID register updates, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= REQ;
      fetch_pc_reg  <= RESET_PC;
      buf_pc_reg    <= '0;
      buf_instr_reg <= '0;
      pc_reg        <= '0;
      instr_reg     <= NOP;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      buf_pc_reg    <= buf_pc_next;
      buf_instr_reg <= buf_instr_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
    end
  end

`ifdef IF_STAGE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_reg;

  // Count NOPs loaded into IF/ID (waits and flushes). Saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bubble_cnt_reg <= '0;
    end else if (load_nop && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_reg;
`else
  logic bubble_unused;
  assign bubble_unused = load_nop;
  assign bubble_cnt    = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage. The stimulus process drives
// one cycle at a time. For each cycle it pushes the expected outputs,
// produced by a behavioural model, into a queue. A monitor on the falling
// edge pops each entry and compares it with the DUT outputs.
// The model keeps the skid buffer as a queue, so an empty queue means a
// fetch is being requested. The bubble counter expectation follows
// IF_STAGE_BUBBLE_CNT_EN.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOPI   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        PCSel;
  logic [31:0] PC_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] bubble_cnt;

  if_stage #(.RESET_PC(RST_PC), .NOP(NOPI)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .PCSel      (PCSel),
    .PC_target  (PC_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .PC         (PC),
    .Instruction(Instruction),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] bub;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_no = 0;

  // Behavioural reference model state.
  logic [31:0] m_fetch, m_pc, m_instr, m_bub;
  logic [63:0] m_skid[$];

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%08h expected=%08h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares one expected entry per cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("imem_req",    e.cyc, {31'd0, imem_req}, e.req);
      check("imem_addr",   e.cyc, imem_addr,   e.addr);
      check("PC",          e.cyc, PC,          e.pc);
      check("Instruction", e.cyc, Instruction, e.instr);
      check("bubble_cnt",  e.cyc, bubble_cnt,  e.bub);
      $display("cyc %0d req=%0b addr=%08h PC=%08h Instr=%08h bub=%0d",
               e.cyc, imem_req, imem_addr, PC, Instruction, bubble_cnt);
    end
  end

  function automatic logic [31:0] bump(input logic [31:0] v);
`ifdef IF_STAGE_BUBBLE_CNT_EN
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
`else
    return v;
`endif
  endfunction

  // Applies one cycle of inputs and records the expected outputs. Then it
  // advances the model across the clock edge.
  task automatic cycle(input logic rst, input logic st, input logic sel,
                       input logic [31:0] tgt, input logic ack,
                       input logic [31:0] data, input bit chk);
    exp_t e;
    reset_n    = rst;
    stall      = st;
    PCSel      = sel;
    PC_target  = tgt;
    imem_ack   = ack;
    imem_rdata = data;
    if (chk) begin
      e.cyc   = cyc_no;
      e.req   = {31'd0, (rst && m_skid.size() == 0)};
      e.addr  = m_fetch;
      e.pc    = m_pc;
      e.instr = m_instr;
      e.bub   = m_bub;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (!rst) begin
      m_fetch = RST_PC; m_pc = 32'd0; m_instr = NOPI; m_bub = 32'd0;
      m_skid.delete();
    end else if (sel) begin
      m_pc = m_fetch; m_instr = NOPI; m_bub = bump(m_bub);
      m_fetch = tgt & 32'hFFFF_FFFC;
      m_skid.delete();
    end else if (m_skid.size() == 0) begin
      if (ack && !st) begin
        m_pc = m_fetch; m_instr = data; m_fetch = m_fetch + 32'd4;
      end else if (ack) begin
        m_skid.push_back({m_fetch, data}); m_fetch = m_fetch + 32'd4;
      end else if (!st) begin
        m_pc = m_fetch; m_instr = NOPI; m_bub = bump(m_bub);
      end
    end else if (!st) begin
      logic [63:0] b;
      b = m_skid.pop_front();
      m_pc = b[63:32]; m_instr = b[31:0];
    end
    cyc_no++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_fetch = RST_PC; m_pc = 0; m_instr = NOPI; m_bub = 0;
    // Reset. The first cycle precedes any edge, so its outputs are unknown.
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1);
    // Zero-wait memory across the wrap: FFFF_FFF8, FFFF_FFFC, 0.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, m_fetch | 32'h13, 1'b1);
    // Ack delayed two cycles on 0x4.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, $urandom, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, $urandom, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, m_fetch | 32'h13, 1'b1);
    // Stall for three cycles, with an ack for 0x8 in the first one.
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, m_fetch | 32'h13, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, $urandom, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, m_fetch | 32'h13, 1'b1);
    // Redirect to 0x103 while stalled in HOLD, which drops the buffer.
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, m_fetch | 32'h13, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h103, 1'b1, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, m_fetch | 32'h13, 1'b1);
    // Reset pulse in mid-stream with the ack still high, then a restart.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, $urandom, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, m_fetch | 32'h13, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, m_fetch | 32'h13, 1'b1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic r, s, p, a;
      r = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 2) != 0);
      cycle(r, s, p, $urandom, a, $urandom, 1'b1);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d expected=0 entries left", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
